// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed show-ahead FIFO and its 1R1W memory.
// Read-during-write mode names select what a same-address read returns.
package sram_fifo_pkg;

  localparam string RDW_NEW_DATA = "NEW_DATA";
  localparam string RDW_OLD_DATA = "OLD_DATA";

endpackage

// File: rtl/sram_fifo_if.sv
// Queue-side port bundle of sram_fifo; the producer/consumer holds the master modport.
// Handshake: enqueue_en is honoured only while full == 0 and dequeue_en only while
// empty == 0; flush_en overrides both. Status outputs are registered.
interface sram_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             flush_en;
  logic             enqueue_en;
  logic [WIDTH-1:0] enqueue_value;
  logic             full;
  logic             almost_full;
  logic             dequeue_en;
  logic [WIDTH-1:0] dequeue_value;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;

  modport master (
    output flush_en, enqueue_en, enqueue_value, dequeue_en,
    input  full, almost_full, dequeue_value, empty, almost_empty, count
  );

  modport slave (
    input  flush_en, enqueue_en, enqueue_value, dequeue_en,
    output full, almost_full, dequeue_value, empty, almost_empty, count
  );

endinterface

// File: rtl/sram_fifo_sram_1r1w.sv
// One-write one-read synchronous SRAM with a registered read port.
// The read register holds its value whenever rd_en is low.
module sram_1r1w
  import sram_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH        = 64,
  parameter int    SIZE              = 8,
  parameter string READ_DURING_WRITE = "NEW_DATA"
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(SIZE)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(SIZE)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam bit NEW_DATA_MODE = (READ_DURING_WRITE == RDW_NEW_DATA);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      // Same-address collision forwards the incoming word in NEW_DATA mode.
      if (NEW_DATA_MODE && wr_en && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/sram_fifo.sv
// Show-ahead FIFO over a 1R1W SRAM: the SRAM read register is the head entry,
// refilled by prefetch so a popped entry is replaced with no bubble.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH                  = 64,
  parameter int DEPTH                  = 8,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input logic        clk,
  input logic        rst_n,
  sram_fifo_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          head_valid;
  logic          full_q;
  logic          almost_full_q;
  logic          empty_q;
  logic          almost_empty_q;

  logic          enq_acc;
  logic          deq_acc;
  logic          rd_issue;
  logic          head_valid_nxt;
  logic [CW-1:0] sram_count;
  logic [CW-1:0] count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    enq_acc        = 1'b0;
    deq_acc        = 1'b0;
    rd_issue       = 1'b0;
    head_valid_nxt = head_valid;
    sram_count     = count_q - CW'(head_valid);
    count_nxt      = count_q;

    enq_acc = rst_n && q.enqueue_en && !full_q && !q.flush_en;
    deq_acc = rst_n && q.dequeue_en && !empty_q && !q.flush_en;

    // With sram_count == 0 the read and write pointers coincide, so a read
    // issued alongside an enqueue picks up the new word via NEW_DATA forwarding.
    rd_issue = (!head_valid || deq_acc) && ((sram_count != '0) || enq_acc) && !q.flush_en;
    head_valid_nxt = rd_issue || (head_valid && !deq_acc);

    case ({enq_acc, deq_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || q.flush_en) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      head_valid     <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= (ALMOST_FULL_THRESHOLD == 0);
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      if (enq_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_issue) rd_ptr <= ptr_inc(rd_ptr);
      count_q        <= count_nxt;
      head_valid     <= head_valid_nxt;
      full_q         <= (int'(count_nxt) == DEPTH);
      almost_full_q  <= (int'(count_nxt) >= ALMOST_FULL_THRESHOLD);
      empty_q        <= (count_nxt == '0);
      almost_empty_q <= (int'(count_nxt) <= ALMOST_EMPTY_THRESHOLD);
    end
  end

  sram_1r1w #(
    .DATA_WIDTH        (WIDTH),
    .SIZE              (DEPTH),
    .READ_DURING_WRITE (RDW_NEW_DATA)
  ) u_sram (
    .clk     (clk),
    .wr_en   (enq_acc),
    .wr_addr (wr_ptr),
    .wr_data (q.enqueue_value),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (q.dequeue_value)
  );

  assign q.count        = count_q;
  assign q.full         = full_q;
  assign q.almost_full  = almost_full_q;
  assign q.empty        = empty_q;
  assign q.almost_empty = almost_empty_q;

  // Misuse is reported but not fatal: the dropped/ignored request is defined behaviour.
  always_ff @(posedge clk) begin
    if (rst_n && !q.flush_en) begin
      assert (!(q.enqueue_en && full_q))
        else $warning("sram_fifo: enqueue while full dropped");
      assert (!(q.dequeue_en && empty_q))
        else $warning("sram_fifo: dequeue while empty ignored");
    end
  end

endmodule

// File: tb/tb_sram_fifo.sv
// Directed bench for sram_fifo: DEPTH 8, almost_full at 6, almost_empty at 2,
// with a queue model supplying every expected head value and count.
module tb_sram_fifo;

  localparam int W     = 64;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  sram_fifo_if #(.WIDTH(W), .DEPTH(DEPTH)) q_if ();

  sram_fifo #(
    .WIDTH                  (W),
    .DEPTH                  (DEPTH),
    .ALMOST_FULL_THRESHOLD  (6),
    .ALMOST_EMPTY_THRESHOLD (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q_if)
  );

  logic [W-1:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One clock with the given request; the model applies the same acceptance rules.
  task automatic cycle(input bit e, input logic [W-1:0] v, input bit d, input bit f);
    bit acc_e;
    bit acc_d;
    q_if.enqueue_en    = e;
    q_if.enqueue_value = v;
    q_if.dequeue_en    = d;
    q_if.flush_en      = f;
    acc_e = e && !f && (exp_q.size() < DEPTH);
    acc_d = d && !f && (exp_q.size() > 0);
    tick();
    if (f) begin
      exp_q.delete();
    end else begin
      if (acc_d) void'(exp_q.pop_front());
      if (acc_e) exp_q.push_back(v);
    end
    q_if.enqueue_en    = 1'b0;
    q_if.enqueue_value = '0;
    q_if.dequeue_en    = 1'b0;
    q_if.flush_en      = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, W'(q_if.count), W'(exp_q.size()));
    check({tag, "_empty"}, W'(q_if.empty), W'(exp_q.size() == 0));
    check({tag, "_full"},  W'(q_if.full),  W'(exp_q.size() == DEPTH));
    if (exp_q.size() != 0) check({tag, "_head"}, q_if.dequeue_value, exp_q[0]);
  endtask

  initial begin
    q_if.flush_en      = 1'b0;
    q_if.enqueue_en    = 1'b0;
    q_if.enqueue_value = '0;
    q_if.dequeue_en    = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // reset state
    check("rst_empty", W'(q_if.empty), 1);
    check("rst_full", W'(q_if.full), 0);
    check("rst_count", W'(q_if.count), 0);
    check("rst_aempty", W'(q_if.almost_empty), 1);
    check("rst_afull", W'(q_if.almost_full), 0);

    // empty bypass: visible one cycle after enqueue
    cycle(1, 64'hA5, 0, 0);
    check("byp_empty", W'(q_if.empty), 0);
    check("byp_value", q_if.dequeue_value, 64'hA5);
    check("byp_count", W'(q_if.count), 1);
    cycle(0, '0, 1, 0);
    check("byp_deq_empty", W'(q_if.empty), 1);
    check("byp_deq_count", W'(q_if.count), 0);

    // fill to full with threshold checks
    for (int i = 1; i <= 8; i++) begin
      cycle(1, W'(i), 0, 0);
      check("fill_head", q_if.dequeue_value, 64'd1);
      check("fill_count", W'(q_if.count), W'(i));
      check("fill_afull", W'(q_if.almost_full), W'(i >= 6));
      check("fill_aempty", W'(q_if.almost_empty), W'(i <= 2));
    end
    check("full_flag", W'(q_if.full), 1);
    cycle(1, 64'd9, 0, 0);
    check_status("drop9");

    // drain back-to-back: one new head every cycle
    for (int i = 1; i <= 8; i++) begin
      check("drain_value", q_if.dequeue_value, W'(i));
      check("drain_empty", W'(q_if.empty), 0);
      cycle(0, '0, 1, 0);
    end
    check_status("drained");
    check("drained_empty", W'(q_if.empty), 1);

    // steady streaming at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1, 64'h100 + W'(i), 0, 0);
    check_status("stream_pre");
    for (int i = 0; i < 20; i++) begin
      check("stream_head", q_if.dequeue_value, exp_q[0]);
      cycle(1, 64'h200 + W'(i), 1, 0);
      check("stream_count", W'(q_if.count), 3);
    end
    for (int i = 17; i < 20; i++) begin
      check("stream_tail", q_if.dequeue_value, 64'h200 + W'(i));
      cycle(0, '0, 1, 0);
    end
    check_status("stream_done");

    // flush beats simultaneous enqueue and dequeue
    for (int i = 0; i < 5; i++) cycle(1, 64'h31 + W'(i), 0, 0);
    check_status("pre_flush");
    cycle(1, 64'h77, 1, 1);
    check("flush_count", W'(q_if.count), 0);
    check("flush_empty", W'(q_if.empty), 1);
    check("flush_aempty", W'(q_if.almost_empty), 1);
    check("flush_afull", W'(q_if.almost_full), 0);
    cycle(1, 64'h11, 0, 0);
    check("post_flush_head", q_if.dequeue_value, 64'h11);
    check_status("post_flush");
    cycle(0, '0, 1, 0);
    check_status("post_flush_drain");

    // reset in mid-operation acts as a flush
    cycle(1, 64'hC1, 0, 0);
    cycle(1, 64'hC2, 0, 0);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    check("midrst_count", W'(q_if.count), 0);
    check("midrst_empty", W'(q_if.empty), 1);
    cycle(1, 64'h55, 0, 0);
    check("midrst_head", q_if.dequeue_value, 64'h55);
    check_status("midrst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
